// File: rtl/ray_gen_if.sv
// Writer-side bus between the camera ray generator and the p_hit input FIFOs.
// Carries the write strobe, the FIFO full flag and the registered ray payload.
interface ray_gen_if #(
    parameter int H_RES = 8,
    parameter int V_RES = 8
);
    localparam int PXW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int PYW = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic                    wr_en;
    logic                    full;
    logic signed [31:0]      origin [2:0];
    logic signed [31:0]      dir    [2:0];
    logic        [PXW-1:0]   px;
    logic        [PYW-1:0]   py;

    modport master (
        output wr_en,
        output origin,
        output dir,
        output px,
        output py,
        input  full
    );

    modport slave (
        input  wr_en,
        input  origin,
        input  dir,
        input  px,
        input  py,
        output full
    );
endinterface

// File: rtl/ray_gen.sv
// Camera ray generator: sweeps an H_RES x V_RES grid in raster order and emits
// one ray per accepted FIFO write, stepping directions with adders only.
module ray_gen #(
    parameter int Q_BITS = 16,
    parameter int H_RES  = 8,
    parameter int V_RES  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] cam_origin [2:0],
    input  logic signed [31:0] dir_base   [2:0],
    input  logic signed [31:0] du         [2:0],
    input  logic signed [31:0] dv         [2:0],
    ray_gen_if.master          bus,
    output logic               busy,
    output logic               done
);
    localparam int PXW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int PYW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [PXW-1:0] PX_LAST = PXW'(H_RES - 1);
    localparam logic [PYW-1:0] PY_LAST = PYW'(V_RES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Directions and origins are raw Q_BITS fixed point; only the range is checked.
    if (Q_BITS < 0 || Q_BITS > 31) begin : g_bad_q_bits
        $error("ray_gen: Q_BITS must be in 0..31");
    end
    if (H_RES < 1 || V_RES < 1) begin : g_bad_res
        $error("ray_gen: H_RES and V_RES must be at least 1");
    end

    logic [1:0]          state_q,   state_d;
    logic signed [31:0]  origin_q  [2:0];
    logic signed [31:0]  origin_d  [2:0];
    logic signed [31:0]  du_q      [2:0];
    logic signed [31:0]  du_d      [2:0];
    logic signed [31:0]  dv_q      [2:0];
    logic signed [31:0]  dv_d      [2:0];
    logic signed [31:0]  row_dir_q [2:0];
    logic signed [31:0]  row_dir_d [2:0];
    logic signed [31:0]  cur_dir_q [2:0];
    logic signed [31:0]  cur_dir_d [2:0];
    logic [PXW-1:0]      px_q,      px_d;
    logic [PYW-1:0]      py_q,      py_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                wr_en;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        origin_d  = origin_q;
        du_d      = du_q;
        dv_d      = dv_q;
        row_dir_d = row_dir_q;
        cur_dir_d = cur_dir_q;
        px_d      = px_q;
        py_d      = py_q;
        wr_en     = (state_q == ST_EMIT) && !bus.full;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    origin_d  = cam_origin;
                    du_d      = du;
                    dv_d      = dv;
                    row_dir_d = dir_base;
                    cur_dir_d = dir_base;
                    px_d      = '0;
                    py_d      = '0;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (wr_en) begin
                    if (px_q != PX_LAST) begin
                        px_d = px_q + 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            cur_dir_d[i] = cur_dir_q[i] + du_q[i];
                        end
                    end else if (py_q != PY_LAST) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                        // The new row start feeds both registers from the pre-update row_dir.
                        for (int i = 0; i < 3; i++) begin
                            row_dir_d[i] = row_dir_q[i] + dv_q[i];
                            cur_dir_d[i] = row_dir_q[i] + dv_q[i];
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: these are a few control registers, not a memory, so resetting all of them is cheap.
            for (int i = 0; i < 3; i++) begin
                origin_q[i]  <= '0;
                du_q[i]      <= '0;
                dv_q[i]      <= '0;
                row_dir_q[i] <= '0;
                cur_dir_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            origin_q  <= origin_d;
            du_q      <= du_d;
            dv_q      <= dv_d;
            row_dir_q <= row_dir_d;
            cur_dir_q <= cur_dir_d;
            px_q      <= px_d;
            py_q      <= py_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bus.origin[i] = origin_q[i];
            bus.dir[i]    = cur_dir_q[i];
        end
    end

    assign bus.wr_en = wr_en;
    assign bus.px    = px_q;
    assign bus.py    = py_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
